dual_port_clear_ram: RTL and testbench
======================================

DUAL_PORT_CLEAR_RAM -- requirements
Module: dual_port_clear_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 12, address bits on both ports.
REQ-003 SHALL have parameter DEPTH, default 4096, number of words; DEPTH <= 2^ADDRESS_WIDTH.
REQ-004 SHALL have parameter CLEAR_VALUE, default 0, word written by the clear sequencer.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; resetn input 1, asynchronous active-low reset.
REQ-006 SHALL have clear input 1, one-cycle request to refill the whole array with CLEAR_VALUE.
REQ-007 SHALL have busy output 1, high while the clear sequencer runs.
REQ-008 SHALL have port A (CPU, read/write): a_en input 1; a_we input 1; a_be input DATA_WIDTH/8; a_addr input ADDRESS_WIDTH; a_wdata input DATA_WIDTH; a_ready output 1; a_rdata output DATA_WIDTH; a_rvalid output 1.
REQ-009 SHALL have port B (VGA, read-only): b_en input 1; b_addr input ADDRESS_WIDTH; b_rdata output DATA_WIDTH; b_rvalid output 1.

Function
REQ-010 SHALL implement FSM states CLEAR and IDLE; all array writes and reads SHALL occur on the rising clk edge.
REQ-011 In CLEAR, SHALL write CLEAR_VALUE to address ptr each cycle, ptr counting 0..DEPTH-1; the write at ptr=DEPTH-1 is the last, and the FSM enters IDLE on that same edge. A full clear therefore takes exactly DEPTH cycles.
REQ-012 In IDLE, clear=1 SHALL load ptr=0 and enter CLEAR on the next edge; clear while in CLEAR SHALL be ignored, with no restart.
REQ-013 busy SHALL be 1 exactly when the state is CLEAR; a_ready SHALL equal ~busy, combinationally.
REQ-014 Port A transfer occurs when a_en & a_ready; a_en while busy SHALL be dropped: no write, no a_rvalid.
REQ-015 A port A write (a_we=1) SHALL update only the bytes whose a_be bit is set; byte i maps to data bits [8i+7:8i].
REQ-016 A port A read (a_we=0) SHALL present the data on a_rdata with a_rvalid=1 exactly one cycle after the transfer.
REQ-017 A port A write SHALL also return the post-write word on a_rdata with a_rvalid=1 one cycle later (write-first).
REQ-018 a_rvalid SHALL be 1 only in the cycle after a transfer; a_rdata SHALL hold its last value otherwise.
REQ-019 Port B read with b_en=1 SHALL present data on b_rdata with b_rvalid=1 one cycle later, in both CLEAR and IDLE. b_en is never blocked by busy.
REQ-020 Port B read SHALL be read-first: if port A or the clear sequencer writes the same address in the same cycle, b_rdata returns the pre-write word.
REQ-021 During CLEAR, a port B read SHALL return CLEAR_VALUE for addresses < ptr and prior contents for addresses >= ptr.
REQ-022 Addresses >= DEPTH SHALL ignore writes and return all-zero read data, with rvalid still asserted.
REQ-023 Array contents SHALL NOT be reset by resetn; only the clear sequencer initialises them.

Reset
REQ-024 While resetn=0: busy=1, state=CLEAR, ptr=0, a_rdata=0, a_rvalid=0, b_rdata=0, b_rvalid=0, a_ready=0.
REQ-025 On resetn release, the clear sequencer SHALL run automatically; busy falls after DEPTH clk edges.
REQ-026 resetn asserted mid-clear or mid-access SHALL abort immediately; the clear restarts from ptr=0 on release, and in-flight read responses are discarded (rvalid=0).

Verification
REQ-027 Release reset with DEPTH=16 and CLEAR_VALUE=0xA5A5A5A5 -> busy stays high exactly 16 cycles; a B-read of every address afterwards returns 0xA5A5A5A5.
REQ-028 In IDLE, write 0x11223344 to addr 5 with a_be=4'b1111, then a_be=4'b0010 with data 0xFFFFFFFF -> a read of addr 5 returns 0x1122FF44 with a_rvalid one cycle after the read.
REQ-029 Same-cycle A write 0xDEADBEEF and B read of addr 7 (old value 0) -> b_rdata=0; a_rdata=0xDEADBEEF next cycle; a later B read returns 0xDEADBEEF.
REQ-030 Pulse clear, then assert a_en write to addr 3 while busy -> a_ready=0 and no a_rvalid; after busy falls, addr 3 reads CLEAR_VALUE. B reads of addr 0 and addr 15 at ptr=8 return CLEAR_VALUE and the old data respectively.
REQ-031 Assert resetn=0 at ptr=9, then release -> busy remains high a further 16 cycles; a_rvalid and b_rvalid are 0 throughout reset.
REQ-032 With DEPTH=12 and ADDRESS_WIDTH=4, A write to addr 13 then A read of addr 13 -> a_rdata=0 and a_rvalid=1; addr 0..11 are unchanged.

Source files
------------

// File: rtl/dual_port_clear_ram.sv
// Dual-port RAM: port A read/write with byte enables (write-first), port B read-only (read-first),
// plus a clear sequencer that fills the whole array with CLEAR_VALUE after reset or on request.
module dual_port_clear_ram #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 12,
    parameter int                    DEPTH         = 4096,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    output logic                       busy,
    input  logic                       a_en,
    input  logic                       a_we,
    input  logic [DATA_WIDTH/8-1:0]    a_be,
    input  logic [ADDRESS_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]      a_wdata,
    output logic                       a_ready,
    output logic [DATA_WIDTH-1:0]      a_rdata,
    output logic                       a_rvalid,
    input  logic                       b_en,
    input  logic [ADDRESS_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]      b_rdata,
    output logic                       b_rvalid,
    output logic                       dbg_state,
    output logic [ADDRESS_WIDTH-1:0]   dbg_ptr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_L  = (ADDRESS_WIDTH + 1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = ADDRESS_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0]    r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]    r_a_rdata;
    logic                     r_a_rvalid;
    logic [DATA_WIDTH-1:0]    r_b_rdata;
    logic                     r_b_rvalid;

    logic                     w_busy;
    logic                     w_a_fire;
    logic                     w_a_in;
    logic                     w_a_wr;
    logic [IDX_W-1:0]         w_a_idx;
    logic [DATA_WIDTH-1:0]    w_a_old;
    logic [DATA_WIDTH-1:0]    w_a_new;
    logic                     w_b_in;
    logic [IDX_W-1:0]         w_b_idx;
    logic                     w_clr_we;
    logic [IDX_W-1:0]         w_clr_idx;

    assign w_busy   = (r_state == ST_CLEAR);
    assign w_a_fire = a_en & ~w_busy;
    assign w_a_in   = ({1'b0, a_addr} < DEPTH_L);
    assign w_b_in   = ({1'b0, b_addr} < DEPTH_L);
    // Out-of-range addresses are steered to word 0 so the array is never indexed past its end.
    assign w_a_idx  = w_a_in ? a_addr[IDX_W-1:0] : '0;
    assign w_b_idx  = w_b_in ? b_addr[IDX_W-1:0] : '0;
    assign w_a_old  = w_a_in ? r_mem[w_a_idx] : '0;
    assign w_a_wr   = w_a_fire & a_we & w_a_in;
    // The sequencer must not write while reset is held, so an aborted clear leaves no trace.
    assign w_clr_we  = w_busy & resetn;
    assign w_clr_idx = r_ptr[IDX_W-1:0];

    always_comb begin
        w_a_new = w_a_old;
        if (a_we) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    w_a_new[8*i +: 8] = a_wdata[8*i +: 8];
                end
            end
        end
        if (!w_a_in) begin
            w_a_new = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_PTR) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        r_ptr   <= '0;
                        r_state <= ST_CLEAR;
                    end
                end
            endcase
        end
    end

    // Array contents survive reset; port B samples the pre-write word through NBA ordering.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_idx] <= CLEAR_VALUE;
        end else if (w_a_wr) begin
            r_mem[w_a_idx] <= w_a_new;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rdata  <= '0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_fire;
            if (w_a_fire) begin
                r_a_rdata <= w_a_new;
            end
            r_b_rvalid <= b_en;
            if (b_en) begin
                r_b_rdata <= w_b_in ? r_mem[w_b_idx] : '0;
            end
        end
    end

    assign busy      = w_busy;
    assign a_ready   = ~w_busy;
    assign a_rdata   = r_a_rdata;
    assign a_rvalid  = r_a_rvalid;
    assign b_rdata   = r_b_rdata;
    assign b_rvalid  = r_b_rvalid;
    assign dbg_state = r_state;
    assign dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_dual_port_clear_ram.sv
// Directed bench for dual_port_clear_ram: a DEPTH=16 instance for the main scenarios and a
// DEPTH=12 instance for out-of-range addressing; both share clock and reset.
module tb_dual_port_clear_ram;

    localparam logic [31:0] CV = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        clear = 1'b0;
    logic        busy;
    logic        a_en = 1'b0, a_we = 1'b0;
    logic [3:0]  a_be = 4'h0;
    logic [3:0]  a_addr = 4'h0;
    logic [31:0] a_wdata = '0;
    logic        a_ready;
    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        b_en = 1'b0;
    logic [3:0]  b_addr = 4'h0;
    logic [31:0] b_rdata;
    logic        b_rvalid;
    logic        dbg_state;
    logic [3:0]  dbg_ptr;

    logic        s_busy;
    logic        s_a_en = 1'b0, s_a_we = 1'b0;
    logic [3:0]  s_a_be = 4'h0;
    logic [3:0]  s_a_addr = 4'h0;
    logic [31:0] s_a_wdata = '0;
    logic        s_a_ready;
    logic [31:0] s_a_rdata;
    logic        s_a_rvalid;
    logic        s_b_en = 1'b0;
    logic [3:0]  s_b_addr = 4'h0;
    logic [31:0] s_b_rdata;
    logic        s_b_rvalid;
    logic        s_dbg_state;
    logic [3:0]  s_dbg_ptr;

    always #5 clk = ~clk;

    dual_port_clear_ram #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .DEPTH(16), .CLEAR_VALUE(CV)
    ) u_dut (
        .clk(clk), .resetn(resetn), .clear(clear), .busy(busy),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    dual_port_clear_ram #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .DEPTH(12), .CLEAR_VALUE(32'h0)
    ) u_small (
        .clk(clk), .resetn(resetn), .clear(1'b0), .busy(s_busy),
        .a_en(s_a_en), .a_we(s_a_we), .a_be(s_a_be), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
        .a_ready(s_a_ready), .a_rdata(s_a_rdata), .a_rvalid(s_a_rvalid),
        .b_en(s_b_en), .b_addr(s_b_addr), .b_rdata(s_b_rdata), .b_rvalid(s_b_rvalid),
        .dbg_state(s_dbg_state), .dbg_ptr(s_dbg_ptr)
    );

    // Inputs change on the falling edge; outputs are captured on the following falling edge.
    task automatic a_access(input logic we, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] be, output logic [31:0] rd, output logic rv);
        @(negedge clk);
        a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = data; a_be = be;
        @(negedge clk);
        rd = a_rdata; rv = a_rvalid;
        a_en = 1'b0; a_we = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] addr, output logic [31:0] rd, output logic rv);
        @(negedge clk);
        b_en = 1'b1; b_addr = addr;
        @(negedge clk);
        rd = b_rdata; rv = b_rvalid;
        b_en = 1'b0;
    endtask

    task automatic s_access(input logic we, input logic [3:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic rv);
        @(negedge clk);
        s_a_en = 1'b1; s_a_we = we; s_a_addr = addr; s_a_wdata = data; s_a_be = 4'hF;
        @(negedge clk);
        rd = s_a_rdata; rv = s_a_rvalid;
        s_a_en = 1'b0; s_a_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        int          n;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, a_ready, a_rvalid, b_rvalid, dbg_state} !== 5'b10000 || dbg_ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b ready=%b arv=%b brv=%b st=%b ptr=%0d, want 1 0 0 0 0 0",
                     busy, a_ready, a_rvalid, b_rvalid, dbg_state, dbg_ptr);
        end
        n_tests++;
        if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got a=%h b=%h, want 0 0", a_rdata, b_rdata);
        end
        resetn = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL reset_busy_cycles: got %0d, want 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            b_read(4'(i), d, v);
            n_tests++;
            if (d !== CV || v !== 1'b1) begin
                n_fail++;
                $display("FAIL b_read_after_clear[%0d]: got %h rv=%b, want %h rv=1", i, d, v, CV);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        logic        v;
        a_access(1'b1, 4'd5, 32'h1122_3344, 4'b1111, d, v);
        n_tests++;
        if (d !== 32'h1122_3344 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL be_full_write_resp: got %h rv=%b, want 11223344 rv=1", d, v);
        end
        a_access(1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0010, d, v);
        n_tests++;
        if (d !== 32'h1122_FF44 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL be_partial_write_resp: got %h rv=%b, want 1122ff44 rv=1", d, v);
        end
        a_access(1'b0, 4'd5, 32'h0, 4'b0000, d, v);
        n_tests++;
        if (d !== 32'h1122_FF44 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL be_read: got %h rv=%b, want 1122ff44 rv=1", d, v);
        end
        @(negedge clk);
        n_tests++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h1122_FF44) begin
            n_fail++;
            $display("FAIL a_rdata_hold: got %h rv=%b, want 1122ff44 rv=0", a_rdata, a_rvalid);
        end
    endtask

    task automatic test_read_first();
        logic [31:0] d;
        logic        v;
        a_access(1'b1, 4'd7, 32'h0, 4'hF, d, v);
        @(negedge clk);
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 32'hDEAD_BEEF; a_be = 4'hF;
        b_en = 1'b1; b_addr = 4'd7;
        @(negedge clk);
        n_tests++;
        if (b_rdata !== 32'h0 || b_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_b_old: got %h rv=%b, want 0 rv=1", b_rdata, b_rvalid);
        end
        n_tests++;
        if (a_rdata !== 32'hDEAD_BEEF || a_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_a_new: got %h rv=%b, want deadbeef rv=1", a_rdata, a_rvalid);
        end
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
        b_read(4'd7, d, v);
        n_tests++;
        if (d !== 32'hDEAD_BEEF || v !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_b_later: got %h rv=%b, want deadbeef rv=1", d, v);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        logic        v;
        int          n;
        a_access(1'b1, 4'd15, 32'h0F0F_0F0F, 4'hF, d, v);
        a_access(1'b1, 4'd3, 32'h3333_3333, 4'hF, d, v);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 1;
        n_tests++;
        if (busy !== 1'b1 || a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start: got busy=%b ready=%b, want 1 0", busy, a_ready);
        end
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'h7777_7777; a_be = 4'hF;
        @(negedge clk);
        n++;
        n_tests++;
        if (a_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop_rvalid: got rv=%b, want 0", a_rvalid);
        end
        a_en = 1'b0; a_we = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        n++;
        clear = 1'b0;
        while (dbg_ptr !== 4'd8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        b_en = 1'b1; b_addr = 4'd0;
        @(negedge clk);
        n++;
        n_tests++;
        if (b_rdata !== CV || b_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_b_below_ptr: got %h rv=%b, want %h rv=1", b_rdata, b_rvalid, CV);
        end
        b_addr = 4'd15;
        @(negedge clk);
        n++;
        n_tests++;
        if (b_rdata !== 32'h0F0F_0F0F || b_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_b_above_ptr: got %h rv=%b, want 0f0f0f0f rv=1", b_rdata, b_rvalid);
        end
        b_en = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL clear_busy_cycles: got %0d, want 16", n);
        end
        a_access(1'b0, 4'd3, 32'h0, 4'h0, d, v);
        n_tests++;
        if (d !== CV || v !== 1'b1) begin
            n_fail++;
            $display("FAIL dropped_write_addr3: got %h rv=%b, want %h rv=1", d, v, CV);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int bad;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (dbg_ptr !== 4'd8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        b_en = 1'b1; b_addr = 4'd1;
        @(negedge clk);
        n_tests++;
        if (dbg_ptr !== 4'd9 || b_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_setup: got ptr=%0d brv=%b, want 9 1", dbg_ptr, b_rvalid);
        end
        resetn = 1'b0;
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd2;
        #1;
        n_tests++;
        if (b_rvalid !== 1'b0 || busy !== 1'b1 || dbg_ptr !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_clear_abort: got brv=%b busy=%b ptr=%0d, want 0 1 0", b_rvalid, busy, dbg_ptr);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rvalid_in_reset: got %0d cycles with rvalid set, want 0", bad);
        end
        a_en = 1'b0; b_en = 1'b0;
        resetn = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL restart_busy_cycles: got %0d, want 16", n);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic        v;
        int          n;
        n = 0;
        while (s_busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 12; i++) begin
            s_access(1'b1, 4'(i), 32'h1000_0000 + 32'(i), d, v);
        end
        s_access(1'b1, 4'd13, 32'hDEAD_BEEF, d, v);
        n_tests++;
        if (d !== 32'h0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write_resp: got %h rv=%b, want 0 rv=1", d, v);
        end
        s_access(1'b0, 4'd13, 32'h0, d, v);
        n_tests++;
        if (d !== 32'h0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read: got %h rv=%b, want 0 rv=1", d, v);
        end
        @(negedge clk);
        s_b_en = 1'b1; s_b_addr = 4'd13;
        @(negedge clk);
        s_b_en = 1'b0;
        n_tests++;
        if (s_b_rdata !== 32'h0 || s_b_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_b_read: got %h rv=%b, want 0 rv=1", s_b_rdata, s_b_rvalid);
        end
        for (int i = 0; i < 12; i++) begin
            s_access(1'b0, 4'(i), 32'h0, d, v);
            n_tests++;
            if (d !== 32'h1000_0000 + 32'(i) || v !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_neighbour[%0d]: got %h rv=%b, want %h rv=1",
                         i, d, v, 32'h1000_0000 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_read_first();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
